// File: rtl/v_pipe_update_arb.sv
// Round-robin arbiter that drains N per-port request FIFOs onto a single registered,
// un-backpressured update bus, one update per cycle, with a stall to freeze issue.

package v_pkg;
  typedef logic [7:0]  id_t;
  typedef logic [1:0]  cmd_t;
  typedef logic [15:0] key_t;
  typedef logic [7:0]  size_t;
endpackage

module v_pipe_update_arb #(
  parameter int unsigned PORTS_N    = 4,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        arst_n,
  input  logic         [PORTS_N-1:0]  i_req_vld,
  output logic         [PORTS_N-1:0]  o_req_rdy,
  input  v_pkg::id_t   [PORTS_N-1:0]  i_req_prod_id,
  input  v_pkg::cmd_t  [PORTS_N-1:0]  i_req_cmd,
  input  v_pkg::key_t  [PORTS_N-1:0]  i_req_key,
  input  v_pkg::size_t [PORTS_N-1:0]  i_req_size,
  input  logic                        i_stall,
  output logic                        o_upd_vld_r,
  output v_pkg::id_t                  o_upd_prod_id_r,
  output v_pkg::cmd_t                 o_upd_cmd_r,
  output v_pkg::key_t                 o_upd_key_r,
  output v_pkg::size_t                o_upd_size_r,
  output logic         [PORTS_N-1:0]  o_port_ne_r,
  output logic                        o_busy
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned PW = (PORTS_N > 1) ? $clog2(PORTS_N) : 1;

  typedef struct packed {
    v_pkg::id_t   prod_id;
    v_pkg::cmd_t  cmd;
    v_pkg::key_t  key;
    v_pkg::size_t size;
  } entry_t;

  typedef logic [AW:0] ptr_t;

  entry_t             mem_q    [PORTS_N][FIFO_DEPTH];
  ptr_t               wr_ptr_q [PORTS_N];
  ptr_t               rd_ptr_q [PORTS_N];
  logic [PORTS_N-1:0] full;
  logic [PORTS_N-1:0] empty;
  logic [PORTS_N-1:0] push;
  logic [PORTS_N-1:0] pop;
  logic [PW-1:0]      rr_q;
  logic [PW-1:0]      rr_d;
  logic [PW-1:0]      gnt_idx;
  logic               gnt_vld;
  entry_t             head;

  // Full and empty come from registered pointers only, so ready never depends on a pop.
  always_comb begin
    for (int unsigned p = 0; p < PORTS_N; p++) begin
      full[p]  = (wr_ptr_q[p] ^ rd_ptr_q[p]) == {1'b1, {AW{1'b0}}};
      empty[p] = (wr_ptr_q[p] == rd_ptr_q[p]);
      push[p]  = i_req_vld[p] & ~full[p];
    end
  end

  assign o_req_rdy   = ~full;
  assign o_port_ne_r = ~empty;
  assign o_busy      = (|o_port_ne_r) | o_upd_vld_r;

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      for (int unsigned p = 0; p < PORTS_N; p++) begin
        wr_ptr_q[p] <= '0;
        rd_ptr_q[p] <= '0;
      end
    end else begin
      for (int unsigned p = 0; p < PORTS_N; p++) begin
        if (push[p]) wr_ptr_q[p] <= wr_ptr_q[p] + ptr_t'(1);
        if (pop[p])  rd_ptr_q[p] <= rd_ptr_q[p] + ptr_t'(1);
      end
    end
  end

  // Storage needs no reset: pointers alone define which entries are live.
  always_ff @(posedge clk) begin
    for (int unsigned p = 0; p < PORTS_N; p++) begin
      if (push[p]) begin
        mem_q[p][wr_ptr_q[p][AW-1:0]] <= '{prod_id: i_req_prod_id[p], cmd: i_req_cmd[p],
                                          key: i_req_key[p], size: i_req_size[p]};
      end
    end
  end

  // First non-empty port at or after the round-robin pointer.
  always_comb begin
    int unsigned idx;
    idx     = 0;
    gnt_vld = 1'b0;
    gnt_idx = '0;
    for (int unsigned i = 0; i < PORTS_N; i++) begin
      idx = (32'(rr_q) + i) % PORTS_N;
      if (!gnt_vld && !empty[PW'(idx)]) begin
        gnt_vld = 1'b1;
        gnt_idx = PW'(idx);
      end
    end
    if (i_stall) gnt_vld = 1'b0;
  end

  always_comb begin
    pop  = '0;
    rr_d = rr_q;
    if (gnt_vld) begin
      pop[gnt_idx] = 1'b1;
      rr_d = (gnt_idx == PW'(PORTS_N - 1)) ? '0 : gnt_idx + PW'(1);
    end
  end

  assign head = mem_q[gnt_idx][rd_ptr_q[gnt_idx][AW-1:0]];

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      rr_q            <= '0;
      o_upd_vld_r     <= 1'b0;
      o_upd_prod_id_r <= '0;
      o_upd_cmd_r     <= '0;
      o_upd_key_r     <= '0;
      o_upd_size_r    <= '0;
    end else begin
      rr_q        <= rr_d;
      o_upd_vld_r <= gnt_vld;
      if (gnt_vld) begin
        o_upd_prod_id_r <= head.prod_id;
        o_upd_cmd_r     <= head.cmd;
        o_upd_key_r     <= head.key;
        o_upd_size_r    <= head.size;
      end
    end
  end

endmodule

// File: tb/tb_v_pipe_update_arb.sv
// Randomised bench for v_pipe_update_arb: a queue-based reference model predicts each
// issued update and its cycle; a negedge monitor pops and compares against the bus.

module tb_v_pipe_update_arb;
  import v_pkg::*;

  localparam int N = 4;
  localparam int D = 4;

  typedef struct packed {
    id_t   id;
    cmd_t  cmd;
    key_t  key;
    size_t size;
  } ent_t;

  typedef struct {
    ent_t e;
    int   stamp;
  } exp_t;

  logic          clk = 1'b0;
  logic          arst_n;
  logic [N-1:0]  vld;
  logic [N-1:0]  rdy;
  logic [N-1:0]  ne;
  id_t  [N-1:0]  pid;
  cmd_t [N-1:0]  cmd;
  key_t [N-1:0]  key;
  size_t [N-1:0] sz;
  logic          stall;
  logic          uvld;
  id_t           upid;
  cmd_t          ucmd;
  key_t          ukey;
  size_t         usz;
  logic          busy;
  ent_t          bus_e;

  ent_t mq[N][$];
  exp_t exp_q[$];
  int   rr_m;
  bit   vld_m;
  ent_t last_e;
  int   cyc = 0;
  int   tests = 0;
  int   fails = 0;

  assign bus_e = {upid, ucmd, ukey, usz};

  v_pipe_update_arb #(.PORTS_N(N), .FIFO_DEPTH(D)) dut (
    .clk(clk), .arst_n(arst_n),
    .i_req_vld(vld), .o_req_rdy(rdy),
    .i_req_prod_id(pid), .i_req_cmd(cmd), .i_req_key(key), .i_req_size(sz),
    .i_stall(stall),
    .o_upd_vld_r(uvld), .o_upd_prod_id_r(upid), .o_upd_cmd_r(ucmd),
    .o_upd_key_r(ukey), .o_upd_size_r(usz),
    .o_port_ne_r(ne), .o_busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input bit ok, input string name, input logic [63:0] act,
                     input logic [63:0] req);
    tests++;
    if (!ok) begin
      fails++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic model_clear();
    for (int p = 0; p < N; p++) mq[p].delete();
    exp_q.delete();
    rr_m   = 0;
    vld_m  = 1'b0;
    last_e = '0;
  endtask

  // Called at posedge+1: drive one cycle of stimulus, check state, advance the model.
  task automatic step(input logic [N-1:0] v, input bit st, input bit fix, input ent_t fe);
    ent_t        inp[N];
    bit          acc[N];
    bit          any;
    int          g;
    int          p;
    logic [63:0] r;
    exp_t        x;
    for (int i = 0; i < N; i++) begin
      r      = {$urandom(), $urandom()};
      inp[i] = fix ? fe : r[$bits(ent_t)-1:0];
      pid[i] = inp[i].id;
      cmd[i] = inp[i].cmd;
      key[i] = inp[i].key;
      sz[i]  = inp[i].size;
    end
    vld   = v;
    stall = st;
    any   = 1'b0;
    for (int i = 0; i < N; i++) begin
      chk(rdy[i] == (mq[i].size() < D), $sformatf("rdy[%0d]", i), 64'(rdy[i]),
          64'(mq[i].size() < D));
      chk(ne[i] == (mq[i].size() > 0), $sformatf("ne[%0d]", i), 64'(ne[i]),
          64'(mq[i].size() > 0));
      any |= (mq[i].size() > 0);
      acc[i] = v[i] && (mq[i].size() < D);
    end
    chk(busy == (any || vld_m), "busy", 64'(busy), 64'(any || vld_m));
    g = -1;
    if (!st) begin
      for (int i = 0; i < N; i++) begin
        p = (rr_m + i) % N;
        if (g < 0 && mq[p].size() > 0) g = p;
      end
    end
    if (g >= 0) begin
      x.e     = mq[g].pop_front();
      x.stamp = cyc + 1;
      exp_q.push_back(x);
      rr_m  = (g + 1) % N;
      vld_m = 1'b1;
    end else begin
      vld_m = 1'b0;
    end
    for (int i = 0; i < N; i++) if (acc[i]) mq[i].push_back(inp[i]);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step('0, 1'b0, 1'b0, '0);
  endtask

  task automatic check_reset_state(input string tag);
    chk(uvld == 1'b0, {tag, " vld"}, 64'(uvld), 64'd0);
    chk(bus_e == '0, {tag, " data"}, 64'(bus_e), 64'd0);
    chk(rdy == '1, {tag, " rdy"}, 64'(rdy), 64'hf);
    chk(ne == '0, {tag, " ne"}, 64'(ne), 64'd0);
    chk(busy == 1'b0, {tag, " busy"}, 64'(busy), 64'd0);
  endtask

  // Asynchronous reset asserted away from any edge; outputs must clear immediately.
  task automatic reset_pulse();
    arst_n = 1'b0;
    vld    = '0;
    stall  = 1'b0;
    #1;
    check_reset_state("async_rst");
    model_clear();
    @(posedge clk);
    #1;
    arst_n = 1'b1;
  endtask

  always @(negedge clk) begin
    if (arst_n) begin
      while (exp_q.size() > 0 && exp_q[0].stamp < cyc) begin
        chk(1'b0, "missed_issue", 64'(exp_q[0].stamp), 64'(cyc));
        void'(exp_q.pop_front());
      end
      if (uvld) begin
        if (exp_q.size() == 0) begin
          chk(1'b0, "unexpected_issue", 64'(bus_e), 64'd0);
        end else begin
          exp_t x;
          x = exp_q.pop_front();
          chk(x.stamp == cyc, "issue_cycle", 64'(cyc), 64'(x.stamp));
          chk(bus_e == x.e, "issue_data", 64'(bus_e), 64'(x.e));
          last_e = x.e;
        end
      end else begin
        chk(bus_e == last_e, "data_hold", 64'(bus_e), 64'(last_e));
      end
    end
  end

  initial begin
    ent_t fe;
    arst_n = 1'b0;
    vld    = '0;
    stall  = 1'b0;
    pid    = '0;
    cmd    = '0;
    key    = '0;
    sz     = '0;
    model_clear();
    @(posedge clk);
    #1;
    check_reset_state("reset");
    arst_n = 1'b1;

    // Single request on port 1 with known payload.
    idle(2);
    fe = '{id: 8'd5, cmd: 2'd1, key: 16'h0010, size: 8'd7};
    step(4'b0010, 1'b0, 1'b1, fe);
    idle(5);

    // All ports loaded with three entries, then released.
    reset_pulse();
    for (int i = 0; i < 3; i++) step(4'b1111, 1'b1, 1'b0, '0);
    idle(14);

    // Port 2 overfilled while stalled.
    reset_pulse();
    for (int i = 0; i < 5; i++) step(4'b0100, 1'b1, 1'b0, '0);
    idle(6);

    // Stall freezes the pointer after a grant to port 0.
    reset_pulse();
    for (int i = 0; i < 2; i++) step(4'b1001, 1'b1, 1'b0, '0);
    step('0, 1'b0, 1'b0, '0);
    for (int i = 0; i < 3; i++) step('0, 1'b1, 1'b0, '0);
    idle(4);

    // Reset while entries are buffered and the bus is valid.
    reset_pulse();
    for (int i = 0; i < 2; i++) step(4'b1111, 1'b1, 1'b0, '0);
    idle(2);
    reset_pulse();
    idle(4);

    // Port 0 streaming back-to-back.
    reset_pulse();
    for (int i = 0; i < 20; i++) step(4'b0001, 1'b0, 1'b0, '0);
    idle(5);

    // Random traffic with occasional stalls and one mid-run reset.
    for (int i = 0; i < 400; i++) begin
      if (i == 200) reset_pulse();
      step(N'($urandom() & $urandom()), ($urandom_range(0, 7) == 0), 1'b0, '0);
    end
    idle(12);
    chk(exp_q.size() == 0, "drain", 64'(exp_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
